// File: rtl/trail_pkg.sv
// trail_pkg -- shared constants and types for the player trail effect.
//
// Used by trail_manager (slot update engine) and by the renderer, so the
// geometry constants (player position/size, particle size) live here once.
//
// Contents:
//   TRAIL_N, LIFE_MAX           default slot count / spawn life
//   TRAIL_SIZE, PLAYER_X,
//   PLAYER_SIZE                 sprite geometry in pixels
//   SPAWN_X                     particle x at spawn (just left of the player)
//   SPAWN_Y_OFS                 particle y offset from player top (centred)
//   trail_state_e               trail_manager FSM states
//   gamemode_e                  game mode encoding on the gamemode bus
//   spawn_y()                   saturating spawn y computation
package trail_pkg;

    localparam int TRAIL_N     = 41;
    localparam int LIFE_MAX    = 10;
    localparam int TRAIL_SIZE  = 8;
    localparam int PLAYER_X    = 160;
    localparam int PLAYER_SIZE = 40;

    // Particle spawns immediately behind the player, vertically centred on it.
    localparam logic [9:0] SPAWN_X     = 10'(PLAYER_X - TRAIL_SIZE);
    localparam int         SPAWN_Y_OFS = PLAYER_SIZE / 2 - TRAIL_SIZE / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SPAWN = 2'd2
    } trail_state_e;

    typedef enum logic [1:0] {
        GM_INIT  = 2'b00,
        GM_PLAY  = 2'b01,
        GM_PAUSE = 2'b10,
        GM_END   = 2'b11
    } gamemode_e;

    // y position of a fresh particle, clamped to the 9-bit screen range.
    function automatic logic [8:0] spawn_y(input logic [8:0] py);
        logic [9:0] sum;
        sum = {1'b0, py} + 10'(SPAWN_Y_OFS);
        return sum[9] ? 9'd511 : sum[8:0];
    endfunction

endpackage

// File: rtl/trail_manager_if.sv
// trail_manager_if -- bus between the game control logic and trail_manager.
//
// Signals:
//   frame_tick   one-cycle pulse at vertical blank start
//   gamemode     00 initial, 01 in-game, 10 paused, 11 ended
//   player_y     player top edge
//   trail_x/y    per-slot particle position (registered in trail_manager)
//   trail_life   per-slot remaining life, 0 = invisible
//   busy         high while a frame update is in progress
//   overrun      sticky: a frame_tick arrived while busy
//
// Modports:
//   master  game side: drives frame_tick/gamemode/player_y, reads trail state
//   slave   trail_manager side
interface trail_manager_if #(
    parameter int TRAIL_N = trail_pkg::TRAIL_N
);

    logic                     frame_tick;
    logic [1:0]               gamemode;
    logic [8:0]               player_y;
    logic [TRAIL_N-1:0][9:0]  trail_x;
    logic [TRAIL_N-1:0][8:0]  trail_y;
    logic [TRAIL_N-1:0][3:0]  trail_life;
    logic                     busy;
    logic                     overrun;

    modport master (
        output frame_tick, gamemode, player_y,
        input  trail_x, trail_y, trail_life, busy, overrun
    );

    modport slave (
        input  frame_tick, gamemode, player_y,
        output trail_x, trail_y, trail_life, busy, overrun
    );

endinterface

// File: rtl/trail_manager.sv
// trail_manager -- ring buffer of trail particles behind the player.
//
// Once per in-game frame the block walks every slot (one per clock), ageing
// live particles, and every SPAWN_DIV frames writes a fresh particle into
// the oldest slot. Spawning happens after the walk so a new particle keeps
// its full life for the frame it appears in.
//
// Ports:
//   clk   single clock
//   rst   asynchronous, active-high reset
//   bus   trail_manager_if.slave (frame_tick, gamemode, player_y in;
//         trail_x/y/life, busy, overrun out -- all outputs registered)
//
// Parameters:
//   TRAIL_N      number of particle slots
//   LIFE_MAX     life loaded at spawn
//   SPAWN_DIV    frames between spawns, 1..15
//   TRAIL_DRIFT  leftward pixels per frame when drift is enabled
//
// Build option:
//   TRAIL_DRIFT_EN  when defined, live particles move left by TRAIL_DRIFT
//                   each frame and die when they would cross x=0.
module trail_manager #(
    parameter int TRAIL_N     = trail_pkg::TRAIL_N,
    parameter int LIFE_MAX    = trail_pkg::LIFE_MAX,
    parameter int SPAWN_DIV   = 2,
    parameter int TRAIL_DRIFT = 4
) (
    input  logic           clk,
    input  logic           rst,
    trail_manager_if.slave bus
);

    import trail_pkg::*;

`ifdef TRAIL_DRIFT_EN
    localparam bit DRIFT_EN = 1'b1;
`else
    localparam bit DRIFT_EN = 1'b0;
`endif

    localparam int               IDX_W    = (TRAIL_N > 1) ? $clog2(TRAIL_N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRAIL_N - 1);
    localparam logic [3:0]       CNT_LAST = 4'(SPAWN_DIV - 1);
    localparam logic [3:0]       LIFE_INIT = 4'(LIFE_MAX);
    localparam logic [9:0]       DRIFT_X  = 10'(TRAIL_DRIFT);

    trail_state_e             state;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         wr_ptr;     // next slot to overwrite (oldest)
    logic [3:0]               spawn_cnt;  // frames since last spawn
    logic                     busy_q;
    logic                     overrun_q;
    logic [TRAIL_N-1:0][9:0]  x_q;
    logic [TRAIL_N-1:0][8:0]  y_q;
    logic [TRAIL_N-1:0][3:0]  life_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            wr_ptr    <= '0;
            spawn_cnt <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            life_q    <= '0;
        end else begin
            // busy_q is only ever high outside IDLE, where the clear below
            // cannot fire, so set and clear never collide.
            if (bus.frame_tick && busy_q)
                overrun_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.gamemode == GM_INIT) begin
                        life_q    <= '0;
                        wr_ptr    <= '0;
                        spawn_cnt <= '0;
                        overrun_q <= 1'b0;
                    end else if (bus.gamemode == GM_PLAY && bus.frame_tick) begin
                        state  <= SCAN;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end

                SCAN: begin
                    if (life_q[idx] != 4'd0) begin
                        if (DRIFT_EN && (x_q[idx] < DRIFT_X)) begin
                            // would leave the screen: kill it, keep x
                            life_q[idx] <= 4'd0;
                        end else begin
                            life_q[idx] <= life_q[idx] - 4'd1;
                            if (DRIFT_EN)
                                x_q[idx] <= x_q[idx] - DRIFT_X;
                        end
                    end

                    if (idx == LAST_IDX) begin
                        if (spawn_cnt == CNT_LAST) begin
                            spawn_cnt <= '0;
                            state     <= SPAWN;
                        end else begin
                            spawn_cnt <= spawn_cnt + 4'd1;
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                SPAWN: begin
                    x_q[wr_ptr]    <= SPAWN_X;
                    y_q[wr_ptr]    <= spawn_y(bus.player_y);
                    life_q[wr_ptr] <= LIFE_INIT;
                    wr_ptr         <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                    state          <= IDLE;
                    busy_q         <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trail_x    = x_q;
    assign bus.trail_y    = y_q;
    assign bus.trail_life = life_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_trail_manager.sv
// tb_trail_manager -- self-checking bench for trail_manager.
// Two instances share stimulus: SPAWN_DIV=1 and SPAWN_DIV=3. A frame-level
// model (one call per accepted frame) predicts every slot, wr_ptr and flags.
module tb_trail_manager;
    import trail_pkg::*;

    localparam int TN    = 41;
    localparam int DRIFT = 4;

`ifdef TRAIL_DRIFT_EN
    localparam bit DRIFT_ON = 1'b1;
`else
    localparam bit DRIFT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] gamemode = 2'b00;
    logic [8:0] player_y = '0;

    always #5 clk = ~clk;

    trail_manager_if #(.TRAIL_N(TN)) bus1 ();
    trail_manager_if #(.TRAIL_N(TN)) bus3 ();

    assign bus1.frame_tick = frame_tick;
    assign bus1.gamemode   = gamemode;
    assign bus1.player_y   = player_y;
    assign bus3.frame_tick = frame_tick;
    assign bus3.gamemode   = gamemode;
    assign bus3.player_y   = player_y;

    trail_manager #(.TRAIL_N(TN), .LIFE_MAX(10), .SPAWN_DIV(1), .TRAIL_DRIFT(DRIFT))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    trail_manager #(.TRAIL_N(TN), .LIFE_MAX(10), .SPAWN_DIV(3), .TRAIL_DRIFT(DRIFT))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // ---------------- reference model (frame granularity) ----------------
    int m_x[2][TN];
    int m_y[2][TN];
    int m_l[2][TN];
    int m_wr[2];
    int m_cnt[2];
    int m_ovr[2];
    int divs[2] = '{1, 3};

    int n_vec = 0;
    int n_err = 0;

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < TN; i++) begin
                m_x[d][i] = 0; m_y[d][i] = 0; m_l[d][i] = 0;
            end
            m_wr[d] = 0; m_cnt[d] = 0; m_ovr[d] = 0;
        end
    endtask

    task automatic m_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < TN; i++) m_l[d][i] = 0;
            m_wr[d] = 0; m_cnt[d] = 0; m_ovr[d] = 0;
        end
    endtask

    task automatic m_frame(input int py);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < TN; i++) begin
                if (m_l[d][i] > 0) begin
                    if (DRIFT_ON && m_x[d][i] < DRIFT) m_l[d][i] = 0;
                    else begin
                        m_l[d][i] = m_l[d][i] - 1;
                        if (DRIFT_ON) m_x[d][i] = m_x[d][i] - DRIFT;
                    end
                end
            end
            if (m_cnt[d] == divs[d] - 1) begin
                m_x[d][m_wr[d]] = 152;
                m_y[d][m_wr[d]] = (py + 16 > 511) ? 511 : py + 16;
                m_l[d][m_wr[d]] = 10;
                m_wr[d] = (m_wr[d] + 1) % TN;
                m_cnt[d] = 0;
            end else begin
                m_cnt[d] = m_cnt[d] + 1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dx(input int d, input int i);
        return (d == 0) ? 32'(bus1.trail_x[i]) : 32'(bus3.trail_x[i]);
    endfunction
    function automatic logic [31:0] dy(input int d, input int i);
        return (d == 0) ? 32'(bus1.trail_y[i]) : 32'(bus3.trail_y[i]);
    endfunction
    function automatic logic [31:0] dl(input int d, input int i);
        return (d == 0) ? 32'(bus1.trail_life[i]) : 32'(bus3.trail_life[i]);
    endfunction
    function automatic logic [31:0] dbusy(input int d);
        return (d == 0) ? 32'(bus1.busy) : 32'(bus3.busy);
    endfunction
    function automatic logic [31:0] dovr(input int d);
        return (d == 0) ? 32'(bus1.overrun) : 32'(bus3.overrun);
    endfunction
    function automatic logic [31:0] dwr(input int d);
        return (d == 0) ? 32'(dut1.wr_ptr) : 32'(dut3.wr_ptr);
    endfunction

    task automatic compare_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < TN; i++) begin
                check($sformatf("%s d%0d x[%0d]", tag, d, i), dx(d, i), 32'(m_x[d][i]));
                check($sformatf("%s d%0d y[%0d]", tag, d, i), dy(d, i), 32'(m_y[d][i]));
                check($sformatf("%s d%0d life[%0d]", tag, d, i), dl(d, i), 32'(m_l[d][i]));
            end
            check($sformatf("%s d%0d busy", tag, d), dbusy(d), 32'd0);
            check($sformatf("%s d%0d overrun", tag, d), dovr(d), 32'(m_ovr[d]));
            check($sformatf("%s d%0d wr_ptr", tag, d), dwr(d), 32'(m_wr[d]));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 m_reset();
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_gm(input logic [1:0] g);
        @(negedge clk);
        gamemode = g;
        @(negedge clk);
        if (g == 2'b00) m_clear();
    endtask

    // One frame: tick, optional extra tick at cycle extra_at, optional
    // gamemode change at cycle 10; busy profile checked against the model.
    task automatic do_frame(input int py, input int extra_at, input int gm_mid);
        int gm0;
        int exp_len[2];
        int cnt[2];
        int first[2];
        gm0 = int'(gamemode);
        for (int d = 0; d < 2; d++) begin
            exp_len[d] = (gm0 == 1) ? ((m_cnt[d] == divs[d] - 1) ? 42 : 41) : 0;
            cnt[d] = 0;
            first[d] = 0;
        end
        @(negedge clk);
        player_y = 9'(py);
        frame_tick = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (dbusy(d) === 32'd1) begin
                    cnt[d]++;
                    if (first[d] == 0) first[d] = k;
                end
            end
            frame_tick = (k == extra_at);
            if (k == 10 && gm_mid >= 0) gamemode = 2'(gm_mid);
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("busy_len d%0d", d), 32'(cnt[d]), 32'(exp_len[d]));
            check($sformatf("busy_first d%0d", d), 32'(first[d]), (exp_len[d] > 0) ? 32'd1 : 32'd0);
            if (extra_at >= 1 && extra_at <= exp_len[d]) m_ovr[d] = 1;
        end
        if (gm0 == 1) m_frame(py);
        if (gamemode == 2'b00) m_clear();
    endtask

    typedef struct {
        logic [8:0] py;
        logic [8:0] exp_y;
    } sat_vec_t;

    sat_vec_t tbl[6];

    initial begin
        tbl[0] = '{py: 9'd200, exp_y: 9'd216};
        tbl[1] = '{py: 9'd0,   exp_y: 9'd16};
        tbl[2] = '{py: 9'd495, exp_y: 9'd511};
        tbl[3] = '{py: 9'd496, exp_y: 9'd511};
        tbl[4] = '{py: 9'd500, exp_y: 9'd511};
        tbl[5] = '{py: 9'd511, exp_y: 9'd511};

        // reset state
        m_reset();
        repeat (3) @(negedge clk);
        compare_all("por");
        rst = 1'b0;

        // first spawn and ageing
        set_gm(2'b01);
        do_frame(200, 0, -1);
        check("spawn x0", dx(0, 0), 32'd152);
        check("spawn y0", dy(0, 0), 32'd216);
        check("spawn life0", dl(0, 0), 32'd10);
        check("spawn wr_ptr", dwr(0), 32'd1);
        do_frame(200, 0, -1);
        check("age life0", dl(0, 0), 32'd9);
        check("age x0", dx(0, 0), DRIFT_ON ? 32'd148 : 32'd152);
        compare_all("two_frames");

        // ring wrap: 42nd spawn lands on slot 0
        for (int f = 0; f < 40; f++) do_frame(100 + f, 0, -1);
        check("wrap life0", dl(0, 0), 32'd10);
        check("wrap wr_ptr", dwr(0), 32'd1);
        compare_all("wrap");

        // overrun: tick while busy is dropped and sticks until gamemode 00
        do_frame(120, 5, -1);
        check("overrun set", dovr(0), 32'd1);
        compare_all("overrun");
        do_frame(130, 0, -1);
        check("overrun sticky", dovr(0), 32'd1);
        set_gm(2'b00);
        check("overrun clr", dovr(0), 32'd0);
        compare_all("gm_init");

        // paused / ended hold everything; gamemode 00 then clears life
        set_gm(2'b01);
        for (int f = 0; f < 3; f++) do_frame(50, 0, -1);
        set_gm(2'b10);
        for (int f = 0; f < 5; f++) do_frame(60, 0, -1);
        compare_all("paused");
        set_gm(2'b11);
        for (int f = 0; f < 2; f++) do_frame(70, 0, -1);
        compare_all("ended");
        set_gm(2'b00);
        compare_all("clear");

        // gamemode change mid-scan: scan completes
        set_gm(2'b01);
        do_frame(300, 0, 2);
        compare_all("mid_gm");

        // spawn y saturation table
        do_reset();
        set_gm(2'b01);
        for (int j = 0; j < 6; j++) begin
            do_frame(int'(tbl[j].py), 0, -1);
            check($sformatf("sat y[%0d]", j), dy(0, j), 32'(tbl[j].exp_y));
            check($sformatf("sat life[%0d]", j), dl(0, j), 32'd10);
        end
        compare_all("sat");

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            int r;
            int ex;
            int gmm;
            logic [1:0] g;
            r = int'($urandom_range(0, 9));
            g = (r < 7) ? 2'b01 : (r == 7) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
            if (g != gamemode) set_gm(g);
            ex = 0;
            gmm = -1;
            if (g == 2'b01) begin
                if ($urandom_range(0, 4) == 0) ex = int'($urandom_range(2, 40));
                if ($urandom_range(0, 9) == 0) gmm = int'($urandom_range(0, 3));
            end
            do_frame(int'($urandom_range(0, 511)), ex, gmm);
            compare_all($sformatf("rnd%0d", f));
        end

        // reset in the middle of a scan
        set_gm(2'b01);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst busy", dbusy(0), 32'd1);
        #2 rst = 1'b1;
        #1 m_reset();
        compare_all("rst_mid");
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
